// File: rtl/cmpe125_rf_pkg.sv
// Shared types and sizes for the decode register file and its writeback path.
//   XLEN   : register data width
//   NREGS  : architectural register count
//   REG_AW : register index width
package cmpe125_rf_pkg;

  localparam int XLEN   = 64;
  localparam int NREGS  = 32;
  localparam int REG_AW = $clog2(NREGS);

  typedef logic [REG_AW-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]   xdata_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered rotation pointer.
// Ports:
//   clk     in  clock
//   rst_n   in  synchronous active-low reset (pointer returns to 0)
//   req     in  N request lines
//   advance in  the granted request was accepted this cycle
//   grant   out one-hot grant, combinational from req and the pointer
module rr_arbiter #(
  parameter int N = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  logic [PW-1:0] ptr_r;
  logic [PW-1:0] ptr_nxt_s;
  logic [PW-1:0] win_idx_s;
  logic          found_s;
  logic          hit_s;

  // Scan from the pointer upward with wrap; the first valid request wins.
  always_comb begin
    grant     = {N{1'b0}};
    win_idx_s = {PW{1'b0}};
    found_s   = 1'b0;
    hit_s     = 1'b0;
    for (int off = 0; off < N; off++) begin
      for (int i = 0; i < N; i++) begin
        hit_s     = (~found_s) & req[i] & (i == ((int'(ptr_r) + off) % N));
        grant[i]  = grant[i] | hit_s;
        win_idx_s = hit_s ? PW'(i) : win_idx_s;
        found_s   = found_s | hit_s;
      end
    end
  end

  // Move the pointer just past the winner once its request is taken.
  always_comb begin
    if (advance & found_s) begin
      if (win_idx_s == PW'(N - 1)) begin
        ptr_nxt_s = {PW{1'b0}};
      end else begin
        ptr_nxt_s = win_idx_s + PW'(1'b1);
      end
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  // Rotation pointer register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_r <= {PW{1'b0}};
    end else begin
      ptr_r <= ptr_nxt_s;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single regfile write port plus the busy
// scoreboard that drives decode hazard detection.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   req_valid/addr/data    NREQ writeback requesters (slice i per requester)
//   req_ready              one-hot grant; a request is taken on valid & ready
//   wr_en/wr_addr/wr_data  registered regfile write port, one cycle after accept
//   issue_valid/issue_rd   decode issuing an instruction that writes issue_rd
//   issue_ready            no WAW hazard on issue_rd
//   rs1, rs2               source registers in decode
//   stall                  RAW hazard on a nonzero busy source
module regfile_wb_arbiter #(
  parameter int NREQ  = 3,
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic [XLEN-1:0]      wr_data,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_rd,
  output logic                 issue_ready,
  input  logic [AW-1:0]        rs1,
  input  logic [AW-1:0]        rs2,
  output logic                 stall
);

  import cmpe125_rf_pkg::*;

  logic [NREQ-1:0]  grant_s;
  logic             win_any_s;
  logic [AW-1:0]    win_addr_s;
  logic [XLEN-1:0]  win_data_s;
  logic             win_wr_s;
  logic             issue_fire_s;
  logic [NREGS-1:0] busy_r;
  logic [NREGS-1:0] busy_nxt_s;
  logic [NREGS-1:0] clr_mask_s;
  logic [NREGS-1:0] set_mask_s;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (win_any_s),
    .grant   (grant_s)
  );

  assign req_ready = grant_s;
  assign win_any_s = |grant_s;

  // One-hot AND-OR mux of the winning requester's address and data.
  always_comb begin
    win_addr_s = {AW{1'b0}};
    win_data_s = {XLEN{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      win_addr_s = win_addr_s | ({AW{grant_s[i]}}   & req_addr[i*AW +: AW]);
      win_data_s = win_data_s | ({XLEN{grant_s[i]}} & req_data[i*XLEN +: XLEN]);
    end
  end

  // x0 writes are accepted but never reach the regfile or the scoreboard.
  assign win_wr_s = win_any_s & (win_addr_s != {AW{1'b0}});

  // Hazards look only at the registered scoreboard, never at the in-flight write.
  always_comb begin
    issue_ready  = (issue_rd == {AW{1'b0}}) | ~busy_r[issue_rd];
    stall        = ((rs1 != {AW{1'b0}}) & busy_r[rs1]) |
                   ((rs2 != {AW{1'b0}}) & busy_r[rs2]);
    issue_fire_s = issue_valid & issue_ready & (issue_rd != {AW{1'b0}});
  end

  // Next scoreboard: clear the written register, then set the issued one so a
  // new producer outranks the retiring one.
  always_comb begin
    clr_mask_s    = win_wr_s ? ({{(NREGS-1){1'b0}}, 1'b1} << win_addr_s) : {NREGS{1'b0}};
    set_mask_s    = issue_fire_s ? ({{(NREGS-1){1'b0}}, 1'b1} << issue_rd) : {NREGS{1'b0}};
    busy_nxt_s    = (busy_r & ~clr_mask_s) | set_mask_s;
    busy_nxt_s[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_r <= {NREGS{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // Registered write port; address/data hold when nothing is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= {AW{1'b0}};
      wr_data <= {XLEN{1'b0}};
    end else begin
      wr_en <= win_wr_s;
      if (win_any_s) begin
        wr_addr <= win_addr_s;
        wr_data <= win_data_s;
      end
    end
  end

endmodule
